// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ctrl_pkg
// Brief  : Shared encodings for the multicycle controller.
// Rev    : 1.0
// ============================================================================
package ctrl_pkg;

    localparam logic [5:0] c_op_r    = 6'b111111;
    localparam logic [5:0] c_op_addi = 6'b110111;
    localparam logic [5:0] c_op_lw   = 6'b100001;
    localparam logic [5:0] c_op_sw   = 6'b100011;
    localparam logic [5:0] c_op_beq  = 6'b111011;
    localparam logic [5:0] c_op_bne  = 6'b100101;
    localparam logic [5:0] c_op_j    = 6'b100010;
    localparam logic [5:0] c_op_jal  = 6'b100111;

    localparam logic [3:0] c_st_fetch  = 4'd0;
    localparam logic [3:0] c_st_decode = 4'd1;
    localparam logic [3:0] c_st_exec_r = 4'd2;
    localparam logic [3:0] c_st_exec_i = 4'd3;
    localparam logic [3:0] c_st_addr   = 4'd4;
    localparam logic [3:0] c_st_mem_rd = 4'd5;
    localparam logic [3:0] c_st_mem_wr = 4'd6;
    localparam logic [3:0] c_st_wb_r   = 4'd7;
    localparam logic [3:0] c_st_wb_i   = 4'd8;
    localparam logic [3:0] c_st_wb_mem = 4'd9;
    localparam logic [3:0] c_st_branch = 4'd10;
    localparam logic [3:0] c_st_jump   = 4'd11;
    localparam logic [3:0] c_st_jal    = 4'd12;
    localparam logic [3:0] c_st_trap   = 4'd13;

    localparam logic [2:0] c_alu_add  = 3'b000;
    localparam logic [2:0] c_alu_beq  = 3'b001;
    localparam logic [2:0] c_alu_func = 3'b010;
    localparam logic [2:0] c_alu_addi = 3'b100;
    localparam logic [2:0] c_alu_bne  = 3'b110;

    localparam logic [1:0] c_pc_seq    = 2'b00;
    localparam logic [1:0] c_pc_branch = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;

    localparam logic [1:0] c_srcb_reg  = 2'b00;
    localparam logic [1:0] c_srcb_four = 2'b01;
    localparam logic [1:0] c_srcb_imm  = 2'b10;
    localparam logic [1:0] c_srcb_imms = 2'b11;

    localparam logic [1:0] c_dst_rt = 2'b00;
    localparam logic [1:0] c_dst_rd = 2'b01;
    localparam logic [1:0] c_dst_ra = 2'b10;

    localparam logic [1:0] c_wb_alu = 2'b00;
    localparam logic [1:0] c_wb_mem = 2'b01;
    localparam logic [1:0] c_wb_pc  = 2'b10;

    typedef enum logic [3:0] {
        CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_word_t;

endpackage
`default_nettype wire

// File: rtl/mc_op_class.sv
`default_nettype none
// ============================================================================
// Module : mc_op_class
// Brief  : Combinational opcode to instruction-class decoder.
// Rev    : 1.0
// ============================================================================
module mc_op_class
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            c_op_r:    op_class = CLS_R;
            c_op_addi: op_class = CLS_ADDI;
            c_op_lw:   op_class = CLS_LW;
            c_op_sw:   op_class = CLS_SW;
            c_op_beq:  op_class = CLS_BEQ;
            c_op_bne:  op_class = CLS_BNE;
            c_op_j:    op_class = CLS_J;
            c_op_jal:  op_class = CLS_JAL;
            default:   op_class = CLS_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Multicycle CPU control FSM with retired-instruction counter.
// Rev    : 1.0
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  instr_op_i,
    input  logic        zero_i,
    input  logic        mem_ack_i,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        IorD_o,
    output logic        IR_write_o,
    output logic        PC_write_o,
    output logic        RegWrite_o,
    output logic        ALUSrcA_o,
    output logic [1:0]  PC_src_o,
    output logic [1:0]  ALUSrcB_o,
    output logic [1:0]  RegDst_o,
    output logic [1:0]  MemtoReg_o,
    output logic [2:0]  ALUOp_o,
    output logic [3:0]  state_o,
    output logic        illegal_o,
    output logic [15:0] retire_cnt_o
);

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [5:0]  r_opcode;
    logic [15:0] r_retire_cnt;
    logic        w_retire;
    op_class_t   w_dec_class;
    op_class_t   w_lat_class;
    ctrl_word_t  w_ctl;
    ctrl_word_t  w_ctl_gated;

    // Live opcode steers DECODE; the latched copy steers ADDR and BRANCH.
    mc_op_class u_dec_class (.opcode(instr_op_i), .op_class(w_dec_class));
    mc_op_class u_lat_class (.opcode(r_opcode),   .op_class(w_lat_class));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_opcode     <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (r_state == c_st_decode) r_opcode <= instr_op_i;
            if (w_retire) r_retire_cnt <= r_retire_cnt + 16'd1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_fetch:  if (mem_ack_i) w_next_state = c_st_decode;
            c_st_decode: begin
                case (w_dec_class)
                    CLS_R:           w_next_state = c_st_exec_r;
                    CLS_ADDI:        w_next_state = c_st_exec_i;
                    CLS_LW, CLS_SW:  w_next_state = c_st_addr;
                    CLS_BEQ, CLS_BNE: w_next_state = c_st_branch;
                    CLS_J:           w_next_state = c_st_jump;
                    CLS_JAL:         w_next_state = c_st_jal;
                    default:         w_next_state = c_st_trap;
                endcase
            end
            c_st_exec_r: w_next_state = c_st_wb_r;
            c_st_exec_i: w_next_state = c_st_wb_i;
            c_st_addr:   w_next_state = (w_lat_class == CLS_SW) ? c_st_mem_wr : c_st_mem_rd;
            c_st_mem_rd: if (mem_ack_i) w_next_state = c_st_wb_mem;
            c_st_mem_wr: if (mem_ack_i) w_next_state = c_st_fetch;
            c_st_wb_r, c_st_wb_i, c_st_wb_mem,
            c_st_branch, c_st_jump, c_st_jal: w_next_state = c_st_fetch;
            c_st_trap:   w_next_state = c_st_trap;
            default:     w_next_state = c_st_fetch;
        endcase
    end

    assign w_retire = (w_next_state == c_st_fetch) &&
                      (r_state inside {c_st_wb_r, c_st_wb_i, c_st_wb_mem, c_st_mem_wr,
                                       c_st_branch, c_st_jump, c_st_jal});

    always_comb begin
        w_ctl = '0;
        case (r_state)
            c_st_fetch: begin
                w_ctl.mem_read = 1'b1;
                if (mem_ack_i) begin
                    w_ctl.ir_write  = 1'b1;
                    w_ctl.pc_write  = 1'b1;
                    w_ctl.pc_src    = c_pc_seq;
                    w_ctl.alu_src_b = c_srcb_four;
                    w_ctl.alu_op    = c_alu_add;
                end
            end
            c_st_decode: begin
                w_ctl.alu_src_b = c_srcb_imms;
                w_ctl.alu_op    = c_alu_add;
            end
            c_st_exec_r: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_srcb_reg;
                w_ctl.alu_op    = c_alu_func;
            end
            c_st_exec_i: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_srcb_imm;
                w_ctl.alu_op    = c_alu_addi;
            end
            c_st_addr: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_srcb_imm;
                w_ctl.alu_op    = c_alu_add;
            end
            c_st_mem_rd: begin
                w_ctl.iord     = 1'b1;
                w_ctl.mem_read = 1'b1;
            end
            c_st_mem_wr: begin
                w_ctl.iord      = 1'b1;
                w_ctl.mem_write = 1'b1;
            end
            c_st_wb_r: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = c_dst_rd;
                w_ctl.mem_to_reg = c_wb_alu;
            end
            c_st_wb_i: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = c_dst_rt;
                w_ctl.mem_to_reg = c_wb_alu;
            end
            c_st_wb_mem: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = c_dst_rt;
                w_ctl.mem_to_reg = c_wb_mem;
            end
            c_st_branch: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = c_srcb_reg;
                w_ctl.pc_src    = c_pc_branch;
                if (w_lat_class == CLS_BNE) begin
                    w_ctl.alu_op   = c_alu_bne;
                    w_ctl.pc_write = !zero_i;
                end else begin
                    w_ctl.alu_op   = c_alu_beq;
                    w_ctl.pc_write = zero_i;
                end
            end
            c_st_jump: begin
                w_ctl.pc_src   = c_pc_jump;
                w_ctl.pc_write = 1'b1;
            end
            c_st_jal: begin
                w_ctl.pc_src     = c_pc_jump;
                w_ctl.pc_write   = 1'b1;
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = c_dst_ra;
                w_ctl.mem_to_reg = c_wb_pc;
            end
            c_st_trap:   w_ctl.illegal = 1'b1;
            default:     w_ctl = '0;
        endcase
    end

    // Holding reset silences every strobe, including the FETCH read request.
    assign w_ctl_gated  = rst_i ? w_ctl : '0;

    assign mem_read_o   = w_ctl_gated.mem_read;
    assign mem_write_o  = w_ctl_gated.mem_write;
    assign IorD_o       = w_ctl_gated.iord;
    assign IR_write_o   = w_ctl_gated.ir_write;
    assign PC_write_o   = w_ctl_gated.pc_write;
    assign RegWrite_o   = w_ctl_gated.reg_write;
    assign ALUSrcA_o    = w_ctl_gated.alu_src_a;
    assign PC_src_o     = w_ctl_gated.pc_src;
    assign ALUSrcB_o    = w_ctl_gated.alu_src_b;
    assign RegDst_o     = w_ctl_gated.reg_dst;
    assign MemtoReg_o   = w_ctl_gated.mem_to_reg;
    assign ALUOp_o      = w_ctl_gated.alu_op;
    assign illegal_o    = w_ctl_gated.illegal;
    assign state_o      = r_state;
    assign retire_cnt_o = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Directed vector bench for multicycle_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam logic [5:0] OP_R    = 6'b111111;
    localparam logic [5:0] OP_ADDI = 6'b110111;
    localparam logic [5:0] OP_LW   = 6'b100001;
    localparam logic [5:0] OP_SW   = 6'b100011;
    localparam logic [5:0] OP_BEQ  = 6'b111011;
    localparam logic [5:0] OP_BNE  = 6'b100101;
    localparam logic [5:0] OP_J    = 6'b100010;
    localparam logic [5:0] OP_JAL  = 6'b100111;

    logic        clk;
    logic        rst;
    logic [5:0]  instr_op;
    logic        zero;
    logic        mem_ack;
    logic        mem_read, mem_write, iord, ir_write, pc_write, reg_write, alu_src_a;
    logic [1:0]  pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic        illegal;
    logic [15:0] retire_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        ack;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst), .instr_op_i(instr_op), .zero_i(zero), .mem_ack_i(mem_ack),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .IorD_o(iord), .IR_write_o(ir_write),
        .PC_write_o(pc_write), .RegWrite_o(reg_write), .ALUSrcA_o(alu_src_a),
        .PC_src_o(pc_src), .ALUSrcB_o(alu_src_b), .RegDst_o(reg_dst), .MemtoReg_o(mem_to_reg),
        .ALUOp_o(alu_op), .state_o(state), .illegal_o(illegal), .retire_cnt_o(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] cw(input logic mr, mw, io, irw, pcw, rw, asa,
                                       input logic [1:0] pcs, asb, rd, m2r,
                                       input logic [2:0] alu, input logic ill);
        return {mr, mw, io, irw, pcw, rw, asa, pcs, asb, rd, m2r, alu, ill};
    endfunction

    function automatic logic [18:0] observed();
        return {mem_read, mem_write, iord, ir_write, pc_write, reg_write, alu_src_a,
                pc_src, alu_src_b, reg_dst, mem_to_reg, alu_op, illegal};
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic a,
                       input logic [3:0] st, input logic [18:0] ctl, input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.op = op; v.zero = z; v.ack = a; v.st = st; v.ctl = ctl; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs after the falling edge, then compare once settled.
    task automatic step(input string name, input logic r, input logic [5:0] op, input logic z,
                        input logic a, input logic [3:0] st, input logic [18:0] ctl,
                        input logic [15:0] cnt);
        @(negedge clk);
        rst = r; instr_op = op; zero = z; mem_ack = a;
        #1;
        checks++;
        if (state !== st) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d", name, state, st);
        end
        checks++;
        if (observed() !== ctl) begin
            errors++;
            $display("FAIL %s ctl: got %b expected %b", name, observed(), ctl);
        end
        checks++;
        if (retire_cnt !== cnt) begin
            errors++;
            $display("FAIL %s retire_cnt: got %h expected %h", name, retire_cnt, cnt);
        end
    endtask

    logic [18:0] F_W, F_A, DEC, EXR, WBR, EXI, WBI, ADR, MRD, WBM, MWR;
    logic [18:0] BEQ_T, BEQ_N, BNE_T, BNE_N, JMP, JAL, TRP, NONE;

    initial begin
        F_W   = cw(1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
        F_A   = cw(1,0,0,1,1,0,0, 2'b00,2'b01,2'b00,2'b00, 3'b000, 0);
        DEC   = cw(0,0,0,0,0,0,0, 2'b00,2'b11,2'b00,2'b00, 3'b000, 0);
        EXR   = cw(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b010, 0);
        WBR   = cw(0,0,0,0,0,1,0, 2'b00,2'b00,2'b01,2'b00, 3'b000, 0);
        EXI   = cw(0,0,0,0,0,0,1, 2'b00,2'b10,2'b00,2'b00, 3'b100, 0);
        WBI   = cw(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
        ADR   = cw(0,0,0,0,0,0,1, 2'b00,2'b10,2'b00,2'b00, 3'b000, 0);
        MRD   = cw(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
        WBM   = cw(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0);
        MWR   = cw(0,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
        BEQ_T = cw(0,0,0,0,1,0,1, 2'b01,2'b00,2'b00,2'b00, 3'b001, 0);
        BEQ_N = cw(0,0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 3'b001, 0);
        BNE_T = cw(0,0,0,0,1,0,1, 2'b01,2'b00,2'b00,2'b00, 3'b110, 0);
        BNE_N = cw(0,0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 3'b110, 0);
        JMP   = cw(0,0,0,0,1,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b000, 0);
        JAL   = cw(0,0,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b10, 3'b000, 0);
        TRP   = cw(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1);
        NONE  = '0;

        // add with two wait cycles, then addi, lw (4-cycle read), sw
        add(1, 0,       0, 0, c_st_fetch,  F_W,   0);
        add(1, 0,       0, 0, c_st_fetch,  F_W,   0);
        add(1, 0,       0, 1, c_st_fetch,  F_A,   0);
        add(1, OP_R,    0, 0, c_st_decode, DEC,   0);
        add(1, OP_R,    0, 1, c_st_exec_r, EXR,   0);
        add(1, 0,       0, 1, c_st_wb_r,   WBR,   0);
        add(1, 0,       0, 1, c_st_fetch,  F_A,   1);
        add(1, OP_ADDI, 0, 0, c_st_decode, DEC,   1);
        add(1, 0,       0, 0, c_st_exec_i, EXI,   1);
        add(1, 0,       0, 0, c_st_wb_i,   WBI,   1);
        add(1, 0,       0, 1, c_st_fetch,  F_A,   2);
        add(1, OP_LW,   0, 0, c_st_decode, DEC,   2);
        add(1, 0,       0, 0, c_st_addr,   ADR,   2);
        add(1, 0,       0, 0, c_st_mem_rd, MRD,   2);
        add(1, 0,       0, 0, c_st_mem_rd, MRD,   2);
        add(1, 0,       0, 0, c_st_mem_rd, MRD,   2);
        add(1, 0,       0, 1, c_st_mem_rd, MRD,   2);
        add(1, 0,       0, 0, c_st_wb_mem, WBM,   2);
        add(1, 0,       0, 1, c_st_fetch,  F_A,   3);
        add(1, OP_SW,   0, 0, c_st_decode, DEC,   3);
        add(1, 0,       0, 0, c_st_addr,   ADR,   3);
        add(1, 0,       0, 0, c_st_mem_wr, MWR,   3);
        add(1, 0,       0, 1, c_st_mem_wr, MWR,   3);
        add(1, 0,       0, 1, c_st_fetch,  F_A,   4);
        // branches in both directions, then j, jal, illegal opcode
        add(1, OP_BEQ,  0, 0, c_st_decode, DEC,   4);
        add(1, 0,       1, 0, c_st_branch, BEQ_T, 4);
        add(1, 0,       0, 1, c_st_fetch,  F_A,   5);
        add(1, OP_BNE,  0, 0, c_st_decode, DEC,   5);
        add(1, 0,       1, 0, c_st_branch, BNE_N, 5);
        add(1, 0,       0, 1, c_st_fetch,  F_A,   6);
        add(1, OP_BEQ,  0, 0, c_st_decode, DEC,   6);
        add(1, 0,       0, 0, c_st_branch, BEQ_N, 6);
        add(1, 0,       0, 1, c_st_fetch,  F_A,   7);
        add(1, OP_BNE,  0, 0, c_st_decode, DEC,   7);
        add(1, 0,       0, 0, c_st_branch, BNE_T, 7);
        add(1, 0,       0, 1, c_st_fetch,  F_A,   8);
        add(1, OP_J,    0, 0, c_st_decode, DEC,   8);
        add(1, 0,       0, 0, c_st_jump,   JMP,   8);
        add(1, 0,       0, 1, c_st_fetch,  F_A,   9);
        add(1, OP_JAL,  0, 0, c_st_decode, DEC,   9);
        add(1, 0,       0, 0, c_st_jal,    JAL,   9);
        add(1, 0,       0, 1, c_st_fetch,  F_A,  10);
        add(1, 6'b0,    0, 0, c_st_decode, DEC,  10);
        add(1, 0,       0, 1, c_st_trap,   TRP,  10);

        rst = 1'b0; instr_op = '0; zero = 1'b0; mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        step("reset", 0, 0, 0, 1, c_st_fetch, NONE, 0);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].ack,
                 vecs[i].st, vecs[i].ctl, vecs[i].cnt);
        end

        // TRAP absorbs stray acks and arbitrary opcodes
        for (int k = 0; k < 10; k++) begin
            step($sformatf("trap%0d", k), 1, 6'($urandom), 1'($urandom), 1,
                 c_st_trap, TRP, 10);
        end

        step("trap_rst",  0, 0, 0, 1, c_st_trap,  NONE, 10);
        step("rst_fetch", 0, 0, 0, 1, c_st_fetch, NONE, 0);

        // Reset while MEM_WR has a coincident ack
        step("j_fetch",  1, 0,     0, 1, c_st_fetch,  F_A, 0);
        step("j_dec",    1, OP_J,  0, 0, c_st_decode, DEC, 0);
        step("j_exec",   1, 0,     0, 0, c_st_jump,   JMP, 0);
        step("sw_fetch", 1, 0,     0, 1, c_st_fetch,  F_A, 1);
        step("sw_dec",   1, OP_SW, 0, 0, c_st_decode, DEC, 1);
        step("sw_addr",  1, 0,     0, 0, c_st_addr,   ADR, 1);
        step("sw_wait",  1, 0,     0, 0, c_st_mem_wr, MWR, 1);
        step("sw_rst",   0, 0,     0, 1, c_st_mem_wr, NONE, 1);
        step("sw_after", 1, 0,     0, 0, c_st_fetch,  F_W, 0);

        // Counter wrap from a preloaded 0xFFFF
        force dut.r_retire_cnt = 16'hFFFF;
        step("wrap_pre", 1, 0,    0, 0, c_st_fetch,  F_W, 16'hFFFF);
        release dut.r_retire_cnt;
        step("wrap_f",   1, 0,    0, 1, c_st_fetch,  F_A, 16'hFFFF);
        step("wrap_d",   1, OP_J, 0, 0, c_st_decode, DEC, 16'hFFFF);
        step("wrap_j",   1, 0,    0, 0, c_st_jump,   JMP, 16'hFFFF);
        step("wrap_end", 1, 0,    0, 0, c_st_fetch,  F_W, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port instr_op_i  in  6  opcode of current IR; sampled only in DECODE.
REQ-004 SHALL have port zero_i  in  1  ALU zero flag, used only in BRANCH.
REQ-005 SHALL have port mem_ack_i  in  1  memory completion, one cycle per access.
REQ-006 SHALL have ports mem_read_o, mem_write_o, IorD_o, IR_write_o, PC_write_o, RegWrite_o, ALUSrcA_o  out  1 each  datapath strobes and selects.
REQ-007 SHALL have ports PC_src_o, ALUSrcB_o, RegDst_o, MemtoReg_o  out  2 each  mux selects.
REQ-008 SHALL have ports ALUOp_o  out  3, state_o  out  4, illegal_o  out  1, retire_cnt_o  out  16.

Function
REQ-009 SHALL recognise opcodes: R 111111, addi 110111, lw 100001, sw 100011, beq 111011, bne 100101, j 100010, jal 100111; all others are illegal.
REQ-010 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, TRAP; state_o carries the encoding.
REQ-011 FETCH: mem_read_o=1, IorD_o=0; holds until mem_ack_i; on ack, same cycle IR_write_o=1, PC_write_o=1, PC_src_o=00, ALUSrcA_o=0, ALUSrcB_o=01, ALUOp_o=000; next DECODE.
REQ-012 DECODE: ALUSrcA_o=0, ALUSrcB_o=11, ALUOp_o=000 (branch target); next R->EXEC_R, addi->EXEC_I, lw/sw->ADDR, beq/bne->BRANCH, j->JUMP, jal->JAL, illegal->TRAP.
REQ-013 EXEC_R: ALUSrcA_o=1, ALUSrcB_o=00, ALUOp_o=010; next WB_R (RegWrite_o=1, RegDst_o=01, MemtoReg_o=00).
REQ-014 EXEC_I: ALUSrcA_o=1, ALUSrcB_o=10, ALUOp_o=100; next WB_I (RegWrite_o=1, RegDst_o=00, MemtoReg_o=00).
REQ-015 ADDR: ALUSrcA_o=1, ALUSrcB_o=10, ALUOp_o=000; next MEM_RD for lw, MEM_WR for sw (opcode latched in DECODE).
REQ-016 MEM_RD: IorD_o=1, mem_read_o=1 until mem_ack_i, then WB_MEM (RegWrite_o=1, RegDst_o=00, MemtoReg_o=01).
REQ-017 MEM_WR: IorD_o=1, mem_write_o=1 until mem_ack_i, then FETCH.
REQ-018 BRANCH: ALUSrcA_o=1, ALUSrcB_o=00, ALUOp_o=001 (beq) / 110 (bne), PC_src_o=01; PC_write_o = beq&zero_i | bne&!zero_i; next FETCH.
REQ-019 JUMP: PC_src_o=10, PC_write_o=1; next FETCH. JAL: additionally RegWrite_o=1, RegDst_o=10, MemtoReg_o=10; next FETCH.
REQ-020 TRAP: illegal_o=1, all strobes 0; absorbing until reset.
REQ-021 Every output not listed for a state SHALL be 0; exactly one of mem_read_o/mem_write_o at most at any time.
REQ-022 mem_ack_i SHALL be ignored in states without an outstanding access.
REQ-023 retire_cnt_o SHALL increment by 1 on each transition into FETCH from WB_R, WB_I, WB_MEM, MEM_WR, BRANCH, JUMP, JAL; wraps FFFF->0000.
REQ-024 Strobes SHALL be combinational from state (plus mem_ack_i, zero_i where stated); no extra latency beyond listed states.

Reset
REQ-025 While rst_i=0 at a clock edge: state<=FETCH, retire_cnt_o<=0, illegal_o<=0, latched opcode<=0.
REQ-026 While rst_i=0, all strobe outputs SHALL be forced 0 (no mem_read_o in FETCH until rst_i=1).
REQ-027 Reset mid-access SHALL abandon the access; a coincident mem_ack_i SHALL have no effect.

Structure
REQ-028 Opcode constants, state encoding, ALUOp codes and mux-select codes SHALL live in shared package ctrl_pkg.
REQ-029 One sub-module mc_op_class SHALL map opcode to instruction class (combinational); FSM and counter stay in multicycle_ctrl.

Verification
REQ-030 add (R) with ack delay 2: FETCH 3 cycles, DECODE, EXEC_R ALUOp=010, WB_R RegWrite=1 RegDst=01; retire_cnt 0->1.
REQ-031 lw, ack delays 0/3: MEM_RD holds mem_read_o=1 IorD_o=1 4 cycles; WB_MEM MemtoReg=01.
REQ-032 beq zero_i=1 -> PC_write_o=1 PC_src_o=01; bne zero_i=1 -> PC_write_o=0; both return to FETCH.
REQ-033 jal -> RegDst=10, MemtoReg=10, RegWrite=1, PC_src=10 single cycle; opcode 000000 -> TRAP, illegal_o stays 1 across 10 cycles with stray mem_ack_i.
REQ-034 rst_i=0 during MEM_WR with mem_ack_i=1 -> next state FETCH, mem_write_o=0, retire_cnt=0; preload 0xFFFF then retire -> 0x0000.
